axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave_pkg.sv | 47 ++++
 rtl/axi_mem_slave.sv | 173 +++++++++++++++++
 tb/tb_axi_mem_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_pkg.sv
// Channel bundles for the single-beat AXI4 memory slave.
package axi_mem_slave_pkg;
  localparam int ID_W = 4;

  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic            awvalid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [3:0]      arqos;
    logic            arvalid;
    logic            rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
  } s_axi_miso_t;
endpackage

// File: rtl/axi_mem_slave.sv
// Single-beat AXI4 memory slave: word-organised RAM with independent read and write FSMs.
// Bursts (len != 0) and out-of-range addresses get SLVERR without touching memory.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int              MEM_KB    = 4,
  parameter logic [31:0]     BASE_ADDR = 32'h0000_0000,
  parameter logic [ID_W-1:0] AXI_ID    = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);
  localparam int          MEM_WORDS = MEM_KB * 256;
  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_KB) * 33'd1024;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic [31:0]     r_mem [MEM_WORDS];
  logic [31:0]     r_awaddr;
  logic [ID_W-1:0] r_awid;
  logic [7:0]      r_awlen;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp;
  logic [ID_W-1:0] r_rid;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;

  logic            w_awready, w_wready, w_arready;
  logic            w_aw_hs, w_w_hs, w_ar_hs;
  logic [31:0]     w_eff_addr, w_eff_data;
  logic [ID_W-1:0] w_eff_id;
  logic [7:0]      w_eff_len;
  logic [3:0]      w_eff_strb;
  logic [32:0]     w_aw_off, w_ar_off;
  logic [IDX_W-1:0] w_aw_idx, w_ar_idx;
  logic            w_wr_ok, w_rd_ok, w_commit, w_mem_we;
  logic            w_unused;

  assign w_awready = !rst && (r_wstate == W_IDLE || r_wstate == W_WAIT_ADDR);
  assign w_wready  = !rst && (r_wstate == W_IDLE || r_wstate == W_WAIT_DATA);
  assign w_arready = !rst && (r_rstate == R_IDLE);
  assign w_aw_hs   = axi_mosi_i.awvalid && w_awready;
  assign w_w_hs    = axi_mosi_i.wvalid && w_wready;
  assign w_ar_hs   = axi_mosi_i.arvalid && w_arready;

  // Whichever half arrived first is taken from the holding registers.
  assign w_eff_addr = (r_wstate == W_WAIT_DATA) ? r_awaddr : axi_mosi_i.awaddr;
  assign w_eff_id   = (r_wstate == W_WAIT_DATA) ? r_awid   : axi_mosi_i.awid;
  assign w_eff_len  = (r_wstate == W_WAIT_DATA) ? r_awlen  : axi_mosi_i.awlen;
  assign w_eff_data = (r_wstate == W_WAIT_ADDR) ? r_wdata  : axi_mosi_i.wdata;
  assign w_eff_strb = (r_wstate == W_WAIT_ADDR) ? r_wstrb  : axi_mosi_i.wstrb;

  // Below-base addresses wrap and set bit 32, so one compare covers both bounds.
  assign w_aw_off = {1'b0, w_eff_addr} - {1'b0, BASE_ADDR};
  assign w_ar_off = {1'b0, axi_mosi_i.araddr} - {1'b0, BASE_ADDR};
  assign w_aw_idx = w_aw_off[IDX_W+1:2];
  assign w_ar_idx = w_ar_off[IDX_W+1:2];
  assign w_wr_ok  = (w_aw_off < MEM_BYTES) && (w_eff_len == 8'd0);
  assign w_rd_ok  = (w_ar_off < MEM_BYTES) && (axi_mosi_i.arlen == 8'd0);

  assign w_commit = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);
  assign w_mem_we = w_commit && w_wr_ok;

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
        else if (w_aw_hs)      w_wstate_nxt = W_WAIT_DATA;
        else if (w_w_hs)       w_wstate_nxt = W_WAIT_ADDR;
      end
      W_WAIT_DATA: if (w_w_hs)  w_wstate_nxt = W_RESP;
      W_WAIT_ADDR: if (w_aw_hs) w_wstate_nxt = W_RESP;
      W_RESP:      if (axi_mosi_i.bready) w_wstate_nxt = W_IDLE;
      default:     w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_awid   <= '0;
      r_awlen  <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bid    <= AXI_ID;
      r_bresp  <= OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_awaddr <= axi_mosi_i.awaddr;
        r_awid   <= axi_mosi_i.awid;
        r_awlen  <= axi_mosi_i.awlen;
      end
      if (w_w_hs) begin
        r_wdata <= axi_mosi_i.wdata;
        r_wstrb <= axi_mosi_i.wstrb;
      end
      if (w_commit) begin
        r_bid   <= w_eff_id;
        r_bresp <= w_wr_ok ? OKAY : SLVERR;
      end
    end
  end

  // Memory is deliberately not reset; handshakes are blocked during reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_eff_strb[i]) r_mem[w_aw_idx][8*i +: 8] <= w_eff_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (axi_mosi_i.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // rdata is captured at the AR handshake, so a same-cycle write is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rid    <= AXI_ID;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rid   <= axi_mosi_i.arid;
        r_rdata <= w_rd_ok ? r_mem[w_ar_idx] : 32'h0;
        r_rresp <= w_rd_ok ? OKAY : SLVERR;
      end
    end
  end

  always_comb begin
    axi_miso_o         = '0;
    axi_miso_o.awready = w_awready;
    axi_miso_o.wready  = w_wready;
    axi_miso_o.bid     = r_bid;
    axi_miso_o.bresp   = r_bresp;
    axi_miso_o.bvalid  = (r_wstate == W_RESP);
    axi_miso_o.arready = w_arready;
    axi_miso_o.rid     = r_rid;
    axi_miso_o.rdata   = r_rdata;
    axi_miso_o.rresp   = r_rresp;
    axi_miso_o.rlast   = (r_rstate == R_RESP);
    axi_miso_o.rvalid  = (r_rstate == R_RESP);
  end

  assign w_unused = ^{axi_mosi_i.awsize, axi_mosi_i.awburst, axi_mosi_i.awlock,
                      axi_mosi_i.awcache, axi_mosi_i.awprot, axi_mosi_i.awqos,
                      axi_mosi_i.wlast, axi_mosi_i.arsize, axi_mosi_i.arburst,
                      axi_mosi_i.arlock, axi_mosi_i.arcache, axi_mosi_i.arprot,
                      axi_mosi_i.arqos};
endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised scoreboard bench for axi_mem_slave against a word-array reference model.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam int          MEM_KB    = 4;
  localparam logic [31:0] BASE      = 32'h0000_2000;
  localparam logic [3:0]  RST_ID    = 4'h5;
  localparam longint      MEM_BYTES = MEM_KB * 1024;
  localparam longint      BASE_L    = 64'h2000;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; } r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  logic [3:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [31:0] ref_mem [int];
  int n_vec = 0, n_err = 0;
  bit auto_b = 1, auto_r = 1;

  always #5 clk = ~clk;

  always_comb begin
    mosi         = '0;
    mosi.awid    = awid;    mosi.awaddr = awaddr; mosi.awlen = awlen;
    mosi.awsize  = 3'd2;    mosi.awburst = 2'b01; mosi.awvalid = awvalid;
    mosi.wdata   = wdata;   mosi.wstrb = wstrb;   mosi.wlast = 1'b1; mosi.wvalid = wvalid;
    mosi.bready  = bready;
    mosi.arid    = arid;    mosi.araddr = araddr; mosi.arlen = arlen;
    mosi.arsize  = 3'd2;    mosi.arburst = 2'b01; mosi.arvalid = arvalid;
    mosi.rready  = rready;
  end

  axi_mem_slave #(.MEM_KB(MEM_KB), .BASE_ADDR(BASE), .AXI_ID(RST_ID)) dut (
    .clk(clk), .rst(rst), .axi_mosi_i(mosi), .axi_miso_o(miso)
  );

  function automatic bit in_rng(input logic [31:0] a);
    longint la;
    la = a;
    return (la >= BASE_L) && (la < BASE_L + MEM_BYTES);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Monitor: pops the oldest expectation whenever a response handshake is about to happen.
  initial begin
    b_exp_t be;
    r_exp_t re;
    forever begin
      @(negedge clk);
      if (!rst && miso.bvalid && bready) begin
        n_vec++;
        if (b_q.size() == 0) begin
          n_err++;
          $display("FAIL b_unexpected: got id=%0h resp=%0h expected no response", miso.bid, miso.bresp);
        end else begin
          be = b_q.pop_front();
          if (miso.bid !== be.id || miso.bresp !== be.resp) begin
            n_err++;
            $display("FAIL b_resp: got id=%0h resp=%0h expected id=%0h resp=%0h",
                     miso.bid, miso.bresp, be.id, be.resp);
          end
        end
      end
      if (!rst && miso.rvalid && rready) begin
        n_vec++;
        if (r_q.size() == 0) begin
          n_err++;
          $display("FAIL r_unexpected: got id=%0h data=%0h expected no response", miso.rid, miso.rdata);
        end else begin
          re = r_q.pop_front();
          if (miso.rid !== re.id || miso.rdata !== re.data || miso.rresp !== re.resp || miso.rlast !== 1'b1) begin
            n_err++;
            $display("FAIL r_resp: got id=%0h data=%0h resp=%0h last=%0b expected id=%0h data=%0h resp=%0h last=1",
                     miso.rid, miso.rdata, miso.rresp, miso.rlast, re.id, re.data, re.resp);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_b) bready = 1'($urandom_range(0, 1));
      if (auto_r) rready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_aw(input int dly, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bit ok = 0;
    repeat (dly) @(posedge clk);
    #1;
    awaddr = a; awid = id; awlen = len; awvalid = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (miso.awready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    awvalid = 0;
    if (!ok) fail_now("aw_handshake");
  endtask

  task automatic send_w(input int dly, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    repeat (dly) @(posedge clk);
    #1;
    wdata = d; wstrb = s; wvalid = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (miso.wready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    wvalid = 0;
    if (!ok) fail_now("w_handshake");
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bit ok = 0;
    #1;
    araddr = a; arid = id; arlen = len; arvalid = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (miso.arready) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    arvalid = 0;
    if (!ok) fail_now("ar_handshake");
  endtask

  task automatic drain(input bit do_b, input bit do_r);
    bit done = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if ((!do_b || b_q.size() == 0) && (!do_r || r_q.size() == 0)) begin done = 1; break; end
    end
    if (!done) begin
      fail_now("drain");
      if (do_b) b_q.delete();
      if (do_r) r_q.delete();
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [31:0] d, input logic [3:0] s);
    b_exp_t e;
    bit ok;
    int k;
    ok = in_rng(a) && (len == 8'd0);
    e.id = id;
    e.resp = ok ? 2'b00 : 2'b10;
    b_q.push_back(e);
    if (ok && s != 4'h0) begin
      k = widx(a);
      if (!ref_mem.exists(k)) ref_mem[k] = 32'h0;
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[k][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic model_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    r_exp_t e;
    bit ok;
    ok = in_rng(a) && (len == 8'd0);
    e.id = id;
    e.data = ok ? ref_mem[widx(a)] : 32'h0;
    e.resp = ok ? 2'b00 : 2'b10;
    r_q.push_back(e);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input bit wait_b);
    model_write(a, id, len, d, s);
    fork
      send_aw(aw_dly, a, id, len);
      send_w(w_dly, d, s);
    join
    check("b_latency", 64'(miso.bvalid), 64'(1));
    if (wait_b) drain(1, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input bit wait_r);
    model_read(a, id, len);
    send_ar(a, id, len);
    check("r_latency", 64'(miso.rvalid), 64'(1));
    if (wait_r) drain(0, 1);
  endtask

  int pool[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 1023};

  initial begin
    logic [31:0] a, d, old;
    logic [3:0]  id, s;
    logic [7:0]  len;
    int k, r;

    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(miso.awready), 64'(0));
    check("rst_wready",  64'(miso.wready),  64'(0));
    check("rst_arready", 64'(miso.arready), 64'(0));
    check("rst_bvalid",  64'(miso.bvalid),  64'(0));
    check("rst_rvalid",  64'(miso.rvalid),  64'(0));
    check("rst_bid",     64'(miso.bid),     64'(RST_ID));
    check("rst_rid",     64'(miso.rid),     64'(RST_ID));
    check("rst_resp",    64'({miso.bresp, miso.rresp}), 64'(0));
    check("rst_rdata",   64'(miso.rdata),   64'(0));
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", 64'({miso.awready, miso.wready, miso.arready}), 64'(3'b111));
    @(posedge clk);
    #1;

    // Seed every word that reads will touch with known full-word data.
    foreach (pool[i]) begin
      if (pool[i] != 8)
        do_write(BASE + 32'(pool[i] * 4), 4'($urandom), 8'd0, $urandom, 4'hF,
                 $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    do_write(BASE + 32'h10, 4'h3, 8'd0, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    do_read(BASE + 32'h10, 4'h9, 8'd0, 1);

    do_write(BASE + 32'h20, 4'h1, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    do_write(BASE + 32'h20, 4'h2, 8'd0, 32'h1234_5678, 4'b0011, 3, 0, 1);
    do_read(BASE + 32'h20, 4'h4, 8'd0, 1);
    check("strb_merge_model", 64'(ref_mem[8]), 64'(32'hFFFF_5678));

    do_read(BASE + 32'(MEM_BYTES), 4'h6, 8'd0, 1);
    do_write(BASE + 32'(MEM_BYTES), 4'h7, 8'd0, 32'hBAD0_BAD0, 4'hF, 0, 1, 1);
    do_read(BASE, 4'h8, 8'd0, 1);
    do_read(BASE - 32'h4, 4'hA, 8'd0, 1);
    do_write(BASE - 32'h4, 4'hB, 8'd0, 32'h0BAD_F00D, 4'hF, 1, 0, 1);
    do_write(BASE + 32'h4, 4'hC, 8'd1, 32'h5555_AAAA, 4'hF, 0, 0, 1);
    do_read(BASE + 32'h4, 4'hD, 8'd0, 1);
    do_read(BASE + 32'h8, 4'hE, 8'd3, 1);
    do_write(BASE + 32'hC, 4'hF, 8'd0, 32'h7777_7777, 4'h0, 0, 0, 1);
    do_read(BASE + 32'hD, 4'h0, 8'd0, 1);
    do_read(BASE + 32'(MEM_BYTES) - 32'h4, 4'h1, 8'd0, 1);

    // Held-off B channel.
    auto_b = 0;
    bready = 0;
    do_write(BASE + 32'h18, 4'hA, 8'd0, 32'hCAFE_0001, 4'hF, 0, 2, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("b_hold_valid", 64'(miso.bvalid), 64'(1));
      check("b_hold_id_resp", 64'({miso.bid, miso.bresp}), 64'({4'hA, 2'b00}));
      check("b_hold_ready", 64'({miso.awready, miso.wready}), 64'(0));
    end
    @(posedge clk);
    #1;
    bready = 1;
    drain(1, 0);
    auto_b = 1;

    // Held-off R channel with a write to the same word underneath it.
    auto_r = 0;
    rready = 0;
    do_write(BASE + 32'h14, 4'h2, 8'd0, 32'h1111_2222, 4'hF, 0, 0, 1);
    do_read(BASE + 32'h14, 4'h3, 8'd0, 0);
    do_write(BASE + 32'h14, 4'h4, 8'd0, 32'h3333_4444, 4'hF, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("r_hold", 64'({miso.rvalid, miso.rid, miso.rdata}), 64'({1'b1, 4'h3, 32'h1111_2222}));
    end
    @(posedge clk);
    #1;
    rready = 1;
    drain(0, 1);
    auto_r = 1;
    do_read(BASE + 32'h14, 4'h5, 8'd0, 1);

    // AR handshake on the same edge as a write commit to that word.
    model_read(BASE + 32'h18, 4'h6, 8'd0);
    model_write(BASE + 32'h18, 4'h7, 8'd0, 32'h9999_8888, 4'hF);
    fork
      send_ar(BASE + 32'h18, 4'h6, 8'd0);
      send_aw(0, BASE + 32'h18, 4'h7, 8'd0);
      send_w(0, 32'h9999_8888, 4'hF);
    join
    drain(1, 1);
    do_read(BASE + 32'h18, 4'h8, 8'd0, 1);

    // Reset while waiting for write data.
    send_aw(0, BASE + 32'h1C, 4'h9, 8'd0);
    @(negedge clk);
    check("wait_data_ready", 64'({miso.awready, miso.wready}), 64'(2'b01));
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bvalid", 64'(miso.bvalid), 64'(0));
    check("mid_rst_ready", 64'({miso.awready, miso.wready}), 64'(0));
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("after_rst_ready", 64'({miso.awready, miso.wready, miso.bvalid}), 64'(3'b110));
    @(posedge clk);
    #1;
    do_read(BASE + 32'h1C, 4'hA, 8'd0, 1);

    // Randomised mix over a small word pool plus out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      id = 4'($urandom);
      r = $urandom_range(0, 11);
      if (r < 10) begin
        k = pool[r];
        a = BASE + 32'(k * 4) + 32'($urandom_range(0, 3));
      end else begin
        k = -1;
        a = (r == 10) ? BASE - 32'($urandom_range(1, 64)) : BASE + 32'(MEM_BYTES) + 32'($urandom_range(0, 64));
      end
      len = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 15)) : 8'd0;
      if ($urandom_range(0, 2) != 0) begin
        d = $urandom;
        s = 4'($urandom);
        if (k >= 0 && !ref_mem.exists(k)) s = 4'hF;
        do_write(a, id, len, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1);
      end else if (k < 0 || ref_mem.exists(k)) begin
        do_read(a, id, len, 1);
      end
    end

    drain(1, 1);
    old = ref_mem[0];
    check("final_word0", 64'(old), 64'(ref_mem[widx(BASE)]));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
